// File: rtl/counter_rmw_stage_pkg.sv
// Shared constants and FSM state type for the adaptive-counter RAM stages.
package counter_rmw_stage_pkg;

  localparam int unsigned PROB_WIDTH_DEFAULT = 12;
  localparam int unsigned PROB_HALF = 1 << (PROB_WIDTH_DEFAULT - 1);
  localparam int unsigned PROB_MAX  = (1 << PROB_WIDTH_DEFAULT) - 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/counter_rmw_stage_prob_adapt.sv
// Shift-based probability adaptation toward the coded bit.
module prob_adapt #(
  parameter int unsigned PROB_WIDTH = 12,
  parameter int unsigned RATE       = 4
) (
  input  logic [PROB_WIDTH-1:0] p,
  input  logic                  cbit,
  output logic [PROB_WIDTH-1:0] p_next
);

  localparam logic [PROB_WIDTH-1:0] MAXV = '1;

  // Both branches stay inside [0, MAXV] by construction, so no clamp is needed.
  always_comb begin
    if (cbit)
      p_next = p + ((MAXV - p) >> RATE);
    else
      p_next = p - (p >> RATE);
  end

endmodule

// File: rtl/counter_rmw_stage.sv
// Read-modify-write stage for one bank of adaptive bit-probability counters,
// with power-up fill to p = 0.5 and single-entry write forwarding.
module counter_rmw_stage
  import counter_rmw_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PROB_WIDTH = 12,
  parameter int unsigned RATE       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROB_WIDTH-1:0] out_prob,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [PROB_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [PROB_WIDTH-1:0] ram_dob
);

  localparam logic [PROB_WIDTH-1:0] HALF = {1'b1, {(PROB_WIDTH-1){1'b0}}};

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    b_valid;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic                    b_bit;
  logic                    byp_hit;
  logic [PROB_WIDTH-1:0]   byp_data;
  logic [PROB_WIDTH-1:0]   p_eff;
  logic [PROB_WIDTH-1:0]   p_new;
  logic                    accept;
  logic                    fire;

  prob_adapt #(
    .PROB_WIDTH (PROB_WIDTH),
    .RATE       (RATE)
  ) u_adapt (
    .p      (p_eff),
    .cbit   (b_bit),
    .p_next (p_new)
  );

  assign p_eff = byp_hit ? byp_data : ram_dob;

  // Handshakes are qualified by reset so a request caught by reset never writes.
  assign in_ready = (state == ST_RUN) && reset && (!b_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = b_valid && out_ready && reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      b_valid  <= 1'b0;
      byp_hit  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_INIT)
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
      if (accept) begin
        b_valid  <= 1'b1;
        b_addr   <= in_addr;
        b_bit    <= in_bit;
        // The RAM returns the pre-write value when read and write collide.
        byp_hit  <= fire && (in_addr == b_addr);
        byp_data <= p_new;
      end else if (fire) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_cnt == '1)
      state_next = ST_RUN;
  end

  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = b_addr;
    ram_dina  = p_new;
    if (state == ST_INIT) begin
      ram_wea   = 1'b1;
      ram_addra = init_cnt;
      ram_dina  = HALF;
    end else begin
      ram_wea = fire;
    end
  end

  assign ram_enb   = accept;
  assign ram_addrb = in_addr;
  assign out_valid = b_valid;
  assign out_prob  = p_eff;

endmodule

// File: tb/tb_counter_rmw_stage.sv
// Randomised and directed bench for counter_rmw_stage against a sequential counter model.
module tb_counter_rmw_stage;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = 12;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic          in_bit;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prob;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [PW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [PW-1:0] ram_dob;

  counter_rmw_stage #(
    .ADDR_WIDTH (AW),
    .PROB_WIDTH (PW),
    .RATE       (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob  (out_prob),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Simple-dual-port RAM with registered, read-before-write read port.
  logic [PW-1:0] tb_ram [1<<AW];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [PW-1:0] poke_data = '0;

  always @(posedge clock) begin
    if (poke_en) tb_ram[poke_addr] <= poke_data;
    else if (ram_wea) tb_ram[ram_addra] <= ram_dina;
    if (ram_enb) ram_dob <= tb_ram[ram_addrb];
  end

  // Reference: requests applied to the counter table strictly in order.
  function automatic int unsigned adapt(input int unsigned p, input logic b);
    if (b) return p + (4095 - p) / 16;
    else   return p - p / 16;
  endfunction

  int unsigned   model_mem [1<<AW];
  int unsigned   exp_a [$];
  int unsigned   exp_p [$];
  int unsigned   exp_n [$];
  int unsigned   log_p [$];
  int unsigned   log_n [$];
  int unsigned   wcount = 0;
  logic          mon_on = 1'b0;
  logic          pv = 1'b0;
  logic [PW-1:0] prev_prob = '0;

  always @(negedge clock) begin
    if (!reset) begin
      foreach (model_mem[i]) model_mem[i] = 2048;
      exp_a.delete(); exp_p.delete(); exp_n.delete();
    end else if (poke_en) begin
      model_mem[poke_addr] = poke_data;
    end
    if (mon_on && reset) begin
      if (pv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_prob", out_prob, prev_prob);
      end
      if (out_valid && out_ready) begin
        if (exp_a.size() == 0) begin
          chk("spurious_fire", 1, 0);
        end else begin
          chk("out_prob", out_prob, exp_p[0]);
          chk("wr_en", ram_wea, 1);
          chk("wr_addr", ram_addra, exp_a[0]);
          chk("wr_data", ram_dina, exp_n[0]);
          void'(exp_a.pop_front()); void'(exp_p.pop_front()); void'(exp_n.pop_front());
        end
        log_p.push_back(out_prob);
        log_n.push_back(ram_dina);
        wcount++;
      end else begin
        chk("wr_idle", ram_wea, 0);
      end
      if (in_valid && in_ready) begin
        int unsigned p;
        chk("rd_en", ram_enb, 1);
        chk("rd_addr", ram_addrb, in_addr);
        p = model_mem[in_addr];
        model_mem[in_addr] = adapt(p, in_bit);
        exp_a.push_back(in_addr);
        exp_p.push_back(p);
        exp_n.push_back(model_mem[in_addr]);
      end else begin
        chk("rd_idle", ram_enb, 0);
      end
      pv = out_valid && !out_ready;
      prev_prob = out_prob;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic b);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; in_addr = a; in_bit = b;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [PW-1:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clock); #1;
    poke_en = 1'b0;
  endtask

  task automatic init_check();
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      @(negedge clock);
      chk("init_wea", ram_wea, 1);
      chk("init_addr", ram_addra, i);
      chk("init_data", ram_dina, 2048);
      chk("init_ready", in_ready, 0);
    end
    @(negedge clock);
    chk("run_ready", in_ready, 1);
    mon_on = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic pair_check(input string name, input int unsigned idx,
                            input int unsigned p0, input int unsigned n0,
                            input int unsigned p1, input int unsigned n1);
    chk({name, "_count"}, log_p.size(), idx + 2);
    if (log_p.size() >= idx + 2) begin
      chk({name, "_p0"}, log_p[idx], p0);
      chk({name, "_n0"}, log_n[idx], n0);
      chk({name, "_p1"}, log_p[idx+1], p1);
      chk({name, "_n1"}, log_n[idx+1], n1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned idx;
    int unsigned w0;
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wea", ram_wea, 1);
    chk("rst_enb", ram_enb, 0);
    chk("rst_addra", ram_addra, 0);
    chk("rst_dina", ram_dina, 2048);
    reset = 1'b1;
    init_check();

    // Single update, then the reverse update on the same counter.
    idx = log_p.size();
    send(5, 1'b1); idle(2);
    send(5, 1'b0); idle(2);
    pair_check("single", idx, 2048, 2175, 2175, 2040);

    // Back-to-back same address.
    idx = log_p.size(); w0 = wcount;
    send(3, 1'b1); send(3, 1'b1); idle(3);
    pair_check("hazard", idx, 2048, 2175, 2175, 2295);
    chk("hazard_writes", wcount - w0, 2);
    chk("hazard_ram", tb_ram[3], 2295);

    // Same hazard with the first result stalled downstream.
    idx = log_p.size(); w0 = wcount;
    out_ready = 1'b0;
    send(7, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(7, 1'b1); idle(3);
    pair_check("stall", idx, 2048, 2175, 2175, 2295);
    chk("stall_writes", wcount - w0, 2);
    chk("stall_ram", tb_ram[7], 2295);

    // Range edges.
    poke(8, 4095); poke(9, 0); poke(10, 15);
    idx = log_p.size();
    send(8, 1'b1); send(9, 1'b0); send(10, 1'b0); idle(3);
    chk("edge_count", log_n.size(), idx + 3);
    if (log_n.size() >= idx + 3) begin
      chk("edge_max", log_n[idx], 4095);
      chk("edge_zero", log_n[idx+1], 0);
      chk("edge_15", log_n[idx+2], 15);
    end

    // Reset with a result pending and downstream ready.
    out_ready = 1'b0;
    send(2, 1'b1);
    mon_on = 1'b0;
    out_ready = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_no_write", ram_wea, 0);
    chk("midrst_ready", in_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_wea", ram_wea, 1);
    chk("midrst_addr", ram_addra, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    init_check();

    for (int unsigned i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      in_bit    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    idle(5);
    chk("drain_empty", exp_a.size(), 0);
    for (int unsigned a = 0; a < (1 << AW); a++)
      chk("final_ram", tb_ram[a], model_mem[a]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
